axis_protocol_monitor: RTL
==========================

# axis_protocol_monitor

Synthesizable, in-system AXI-Stream protocol monitor. It watches one stream interface without driving it, and raises sticky per-rule error flags. It also keeps packet byte, stall and optional traffic counters. It taps any AXI-Stream link in the design for on-chip debug or bus-readable status, and checks at runtime the same handshake, payload-stability and packet-length rules that the team's formal stream properties check in proofs.

## Interface
Parameters:
- DW, 32, TDATA width in bits; multiple of 8.
- IDW, 1, TID width.
- DESTW, 1, TDEST width.
- UW, 1, TUSER width.
- LGDEPTH, 16, width of the byte, stall and statistic counters.
- MAX_PACKET, 0, maximum packet length in bytes; 0 disables the check.
- MIN_PACKET, 0, minimum packet length in bytes; 0 disables the check.
- MAX_STALL, 0, maximum consecutive cycles of TVALID && !TREADY; 0 disables the check.

Ports:
- i_aclk  in  1  clock.
- i_aresetn  in  1  asynchronous, active-low reset.
- i_tvalid, i_tready, i_tlast  in  1  monitored handshake and last.
- i_tdata  in  DW  monitored data.
- i_tstrb, i_tkeep  in  DW/8  monitored byte qualifiers.
- i_tid  in  IDW; i_tdest  in  DESTW; i_tuser  in  UW  monitored sideband.
- i_clear  in  1  synchronous clear of the sticky errors.
- o_err  out  7  sticky error vector; bit map under Operation.
- o_err_any  out  1  OR of o_err, registered together with it.
- o_bytecount  out  LGDEPTH  bytes accepted so far in the current packet.
- o_stall_count  out  LGDEPTH  current consecutive stall cycles.
- o_pkt_count, o_beat_count  out  LGDEPTH  statistics; present only with the macro.

## Operation
- A beat is accepted when TVALID && TREADY. Valid bytes in a beat = popcount(TKEEP & TSTRB).
- A stall is TVALID && !TREADY. The monitor registers a snapshot of the full payload (DATA, STRB, KEEP, LAST, ID, DEST, USER) and a `stalled` flag each cycle.
- Error bits. Each one sets on the clock edge after the offending cycle:
  - [0] VALID_DROP: `stalled` was set and TVALID is now low.
  - [1] PAYLOAD_CHANGE: `stalled` was set, and STRB, KEEP, LAST, ID, DEST or USER differs from the snapshot, or any data byte with the snapshot TKEEP bit high differs. Bytes whose snapshot TKEEP bit is low are ignored.
  - [2] RESERVED_STRB: TVALID && (TSTRB & ~TKEEP) != 0.
  - [3] MAX_PKT: accepted beat with o_bytecount + vbytes > MAX_PACKET.
  - [4] MIN_PKT: accepted TLAST beat with o_bytecount + vbytes < MIN_PACKET.
  - [5] STALL: o_stall_count reaches MAX_STALL.
  - [6] VALID_AFTER_RESET: TVALID high in the first cycle after reset deasserts.
- Error flags stay set until i_clear or reset.
- If i_clear and a new error occur in the same cycle, the new error bit is set and all other bits clear.
- o_bytecount:
  - Accepted TLAST beat: goes to 0.
  - Other accepted beat: adds vbytes, saturating at all-ones.
  - No accepted beat: holds.
- o_stall_count:
  - Stall cycle: increments, saturating at all-ones.
  - Any other cycle: goes to 0.
- Reset asserted mid-packet: every register clears immediately. The first cycle after release is checked for rule [6] only.

## Timing
- Every output is registered and is 0 during reset.
- Error flags show one cycle after the violating input cycle.
- The counters update on the same edge as the accepted beat or stall cycle.
- The monitor never drives TREADY. No combinational path from inputs to outputs.
- The stability check is armed only when the previous cycle was a stall and reset was high in both cycles.

## Configuration
- AXISMON_STATS_EN defined: o_pkt_count counts accepted TLAST beats and o_beat_count counts accepted beats. Both wrap modulo 2^LGDEPTH and clear only on reset.
- AXISMON_STATS_EN undefined: both counters are not built and both outputs are tied to 0.

## Test plan
- DW=32, four packets of 3 full beats, TREADY always high -> o_err = 0; o_bytecount reads 0, 4, 8, then 0 after the TLAST beat; with the macro, o_pkt_count = 4 and o_beat_count = 12.
- Stall with TKEEP=4'b0011; change byte 3 -> no error. Then change byte 0 -> o_err[1] set on the next edge and stays set until i_clear; o_err_any high.
- MAX_STALL=5, TVALID high, TREADY low for 5 cycles -> o_err[5] set on the edge where o_stall_count reaches 5. Then drop TVALID before TREADY rises -> o_err[0] also set.
- MAX_PACKET=8, MIN_PACKET=6, beats of 4 bytes: a 3-beat packet sets [3] on its third beat; a 1-beat TLAST packet sets [4].
- TSTRB=4'b1000, TKEEP=4'b0111, TVALID high -> o_err[2] set. Then pulse i_clear in the same cycle as a VALID_DROP -> o_err = 7'b0000001.
- Assert reset with o_bytecount = 8 mid-packet -> all outputs 0 immediately. TVALID high in the first cycle after release -> o_err[6] set.

Source files
------------

// File: rtl/axis_protocol_monitor.sv
// Passive AXI-Stream monitor: sticky per-rule error flags plus packet byte and stall counters.
// Define AXISMON_STATS_EN to build the accepted-packet and accepted-beat statistics counters.
module axis_protocol_monitor #(
  parameter int DW         = 32,
  parameter int IDW        = 1,
  parameter int DESTW      = 1,
  parameter int UW         = 1,
  parameter int LGDEPTH    = 16,
  parameter int MAX_PACKET = 0,
  parameter int MIN_PACKET = 0,
  parameter int MAX_STALL  = 0
) (
  input  logic                 i_aclk,
  input  logic                 i_aresetn,
  input  logic                 i_tvalid,
  input  logic                 i_tready,
  input  logic                 i_tlast,
  input  logic [DW-1:0]        i_tdata,
  input  logic [DW/8-1:0]      i_tstrb,
  input  logic [DW/8-1:0]      i_tkeep,
  input  logic [IDW-1:0]       i_tid,
  input  logic [DESTW-1:0]     i_tdest,
  input  logic [UW-1:0]        i_tuser,
  input  logic                 i_clear,
  output logic [6:0]           o_err,
  output logic                 o_err_any,
  output logic [LGDEPTH-1:0]   o_bytecount,
  output logic [LGDEPTH-1:0]   o_stall_count,
  output logic [LGDEPTH-1:0]   o_pkt_count,
  output logic [LGDEPTH-1:0]   o_beat_count
);
  localparam int NB = DW / 8;
  localparam int LW = LGDEPTH + 1;
  localparam logic [LW-1:0]      MAXP = LW'(MAX_PACKET);
  localparam logic [LW-1:0]      MINP = LW'(MIN_PACKET);
  localparam logic [LGDEPTH-1:0] MAXS = LGDEPTH'(MAX_STALL);

  logic [DW-1:0]      data_q;
  logic [NB-1:0]      strb_q, keep_q;
  logic               last_q;
  logic [IDW-1:0]     id_q;
  logic [DESTW-1:0]   dest_q;
  logic [UW-1:0]      user_q;
  logic               stalled_q, stalled_d;
  logic               armed_q;
  logic [6:0]         err_q, err_d, new_err;
  logic               err_any_q, err_any_d;
  logic [LGDEPTH-1:0] bytecount_q, bytecount_d;
  logic [LGDEPTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [LW-1:0]      vbytes, sum;
  logic               accept, data_diff, side_diff;

  always_comb begin
    accept    = i_tvalid && i_tready;
    stalled_d = i_tvalid && !i_tready;
    vbytes    = '0;
    data_diff = 1'b0;
    for (int i = 0; i < NB; i++) begin
      vbytes = vbytes + LW'(i_tkeep[i] & i_tstrb[i]);
      // Bytes the source marked as null in the held beat may legally change
      if (keep_q[i] && (i_tdata[8*i +: 8] != data_q[8*i +: 8])) data_diff = 1'b1;
    end
    side_diff = (i_tstrb != strb_q) || (i_tkeep != keep_q) || (i_tlast != last_q) ||
                (i_tid != id_q) || (i_tdest != dest_q) || (i_tuser != user_q);
    sum = LW'(bytecount_q) + vbytes;

    if (accept && i_tlast)   bytecount_d = '0;
    else if (accept)         bytecount_d = sum[LGDEPTH] ? '1 : sum[LGDEPTH-1:0];
    else                     bytecount_d = bytecount_q;

    if (stalled_d)           stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
    else                     stall_cnt_d = '0;

    new_err    = '0;
    new_err[0] = stalled_q && !i_tvalid;
    new_err[1] = stalled_q && (data_diff || side_diff);
    new_err[2] = i_tvalid && ((i_tstrb & ~i_tkeep) != '0);
    new_err[3] = (MAX_PACKET != 0) && accept && (sum > MAXP);
    new_err[4] = (MIN_PACKET != 0) && accept && i_tlast && (sum < MINP);
    new_err[5] = (MAX_STALL != 0) && stalled_d && (stall_cnt_d == MAXS);
    // The first cycle out of reset only checks that the source is not already asserting valid
    if (!armed_q) new_err = {i_tvalid, 6'b0};

    err_d     = i_clear ? new_err : (err_q | new_err);
    err_any_d = |err_d;
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      data_q      <= '0;
      strb_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      id_q        <= '0;
      dest_q      <= '0;
      user_q      <= '0;
      stalled_q   <= 1'b0;
      armed_q     <= 1'b0;
      err_q       <= '0;
      err_any_q   <= 1'b0;
      bytecount_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      data_q      <= i_tdata;
      strb_q      <= i_tstrb;
      keep_q      <= i_tkeep;
      last_q      <= i_tlast;
      id_q        <= i_tid;
      dest_q      <= i_tdest;
      user_q      <= i_tuser;
      stalled_q   <= stalled_d;
      armed_q     <= 1'b1;
      err_q       <= err_d;
      err_any_q   <= err_any_d;
      bytecount_q <= bytecount_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_err         = err_q;
  assign o_err_any     = err_any_q;
  assign o_bytecount   = bytecount_q;
  assign o_stall_count = stall_cnt_q;

`ifdef AXISMON_STATS_EN
  logic [LGDEPTH-1:0] pkt_q, pkt_d, beat_q, beat_d;

  always_comb begin
    pkt_d  = (accept && i_tlast) ? pkt_q + 1'b1 : pkt_q;
    beat_d = accept ? beat_q + 1'b1 : beat_q;
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      pkt_q  <= '0;
      beat_q <= '0;
    end else begin
      pkt_q  <= pkt_d;
      beat_q <= beat_d;
    end
  end

  assign o_pkt_count  = pkt_q;
  assign o_beat_count = beat_q;
`else
  assign o_pkt_count  = '0;
  assign o_beat_count = '0;
`endif

endmodule
